// File: rtl/ks_add_arbiter_if.sv
// Bus bundle between the requesters/consumer and the shared-adder arbiter.
// The master side is the client logic; the slave side is ks_add_arbiter.
interface ks_add_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] A;
  logic [NREQ*WIDTH-1:0] B;
  logic [NREQ-1:0]       CI;
  logic [NREQ-1:0]       GNT;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [1:0]            OUT_ID;
  logic [WIDTH-1:0]      SUM;
  logic                  COUT;
  logic                  BUSY;

  modport master (
    output REQ, A, B, CI, OUT_READY,
    input  GNT, OUT_VALID, OUT_ID, SUM, COUT, BUSY
  );

  modport slave (
    input  REQ, A, B, CI, OUT_READY,
    output GNT, OUT_VALID, OUT_ID, SUM, COUT, BUSY
  );
endinterface

// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter feeding one shared 16-bit Kogge-Stone adder through a
// two-stage pipeline (operand register S1, result register S2) with
// valid/ready backpressure on the result side.

// Purely combinational 16-bit Kogge-Stone adder: generate/propagate,
// four prefix layers (span 1, 2, 4, 8) and the sum stage.
module ks_add16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_ci,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_hp;
  logic [15:0] w_g;
  logic [15:0] w_p;

  // Prefix tree; carry-in is folded into bit 0's generate so that after the
  // last layer w_g[i] is the carry out of bit i.
  always_comb begin
    w_hp   = i_a ^ i_b;
    w_g    = i_a & i_b;
    w_g[0] = w_g[0] | (w_hp[0] & i_ci);
    w_p    = w_hp;
    for (int l = 0; l < 4; l++) begin
      // Low bits shift in zeros, so group terms below the span pass through.
      w_g = w_g | (w_p & (w_g << (1 << l)));
      w_p = w_p & (w_p << (1 << l));
    end
    o_sum  = w_hp ^ {w_g[14:0], i_ci};
    o_cout = w_g[15];
  end
endmodule

module ks_add_arbiter #(
  parameter int WIDTH = 16,  // only 16 matches the four prefix layers
  parameter int NREQ  = 4    // fixed at 4: 2-bit requester ID
) (
  input logic              CLK,
  input logic              RST,
  ks_add_arbiter_if.slave  bus
);
  localparam int ID_W = 2;

  // Stage S1: operand register
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_a_p1;
  logic [WIDTH-1:0] r_b_p1;
  logic             r_ci_p1;
  logic [ID_W-1:0]  r_id_p1;

  // Stage S2: result register
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2;
  logic [ID_W-1:0]  r_id_p2;

  logic [ID_W-1:0]  r_ptr;

  logic             w_adv2;
  logic             w_load1;
  logic             w_gnt_any;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W-1:0]  w_scan;
  logic [NREQ-1:0]  w_gnt;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_adv2  = r_vld_p1 & (~r_vld_p2 | bus.OUT_READY);
  assign w_load1 = ~r_vld_p1 | w_adv2;

  // Round-robin pick starting at r_ptr; no grant while S1 cannot accept or in reset.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    w_scan    = r_ptr;
    w_gnt     = '0;
    if (!RST && w_load1) begin
      for (int k = 0; k < NREQ; k++) begin
        w_scan = r_ptr + ID_W'(k);
        if (!w_gnt_any && bus.REQ[w_scan]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_scan;
        end
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  // Pipeline control, round-robin pointer and the reset-visible S2 result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_ptr     <= '0;
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
      r_id_p2   <= '0;
    end else begin
      if (w_gnt_any) begin
        r_vld_p1 <= 1'b1;
        r_ptr    <= w_gnt_idx + ID_W'(1);
      end else if (w_adv2) begin
        r_vld_p1 <= 1'b0;
      end

      if (w_adv2) begin
        r_vld_p2  <= 1'b1;
        r_sum_p2  <= w_sum;
        r_cout_p2 <= w_cout;
        r_id_p2   <= r_id_p1;
      end else if (bus.OUT_READY) begin
        r_vld_p2 <= 1'b0;
      end
    end
  end

  // S1 operand capture for the granted requester; qualified by r_vld_p1, so no reset.
  always_ff @(posedge CLK) begin
    if (w_gnt_any) begin
      r_a_p1  <= bus.A[w_gnt_idx*WIDTH +: WIDTH];
      r_b_p1  <= bus.B[w_gnt_idx*WIDTH +: WIDTH];
      r_ci_p1 <= bus.CI[w_gnt_idx];
      r_id_p1 <= w_gnt_idx;
    end
  end

  // Shared adder: S1 registers -> adder -> S2 registers, nothing else in the path.
  ks_add16 u_core (
    .i_a    (r_a_p1),
    .i_b    (r_b_p1),
    .i_ci   (r_ci_p1),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign bus.GNT       = w_gnt;
  assign bus.OUT_VALID = r_vld_p2;
  assign bus.OUT_ID    = r_id_p2;
  assign bus.SUM       = r_sum_p2;
  assign bus.COUT      = r_cout_p2;
  assign bus.BUSY      = r_vld_p1 | r_vld_p2;
endmodule

// File: tb/tb_ks_add_arbiter.sv
// Directed bench for ks_add_arbiter: single ops, carry cases, round-robin
// order, backpressure, pointer fairness and asynchronous reset mid-flight.
module tb_ks_add_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ks_add_arbiter_if bus ();

  ks_add_arbiter dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus.A[k*16 +: 16] = a;
    bus.B[k*16 +: 16] = b;
    bus.CI[k]         = ci;
  endtask

  // One isolated transaction on requester k; result expected two cycles after grant.
  task automatic run_add(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] exp_sum, input logic exp_cout);
    set_op(k, a, b, ci);
    bus.REQ = 4'(1 << k);
    @(negedge clk);
    check("add_gnt", 32'(bus.GNT), 32'(1 << k));
    tick();
    bus.REQ = 4'b0000;
    @(negedge clk);
    check("add_vld_n1", 32'(bus.OUT_VALID), 32'd0);
    tick();
    @(negedge clk);
    check("add_vld_n2", 32'(bus.OUT_VALID), 32'd1);
    check("add_sum", 32'(bus.SUM), 32'(exp_sum));
    check("add_cout", 32'(bus.COUT), 32'(exp_cout));
    check("add_id", 32'(bus.OUT_ID), 32'(k));
    tick();
    @(negedge clk);
    check("add_idle", 32'(bus.BUSY), 32'd0);
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.REQ       = 4'b1111;
    bus.A         = '0;
    bus.B         = '0;
    bus.CI        = '0;
    bus.OUT_READY = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    check("rst_vld", 32'(bus.OUT_VALID), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_sum", 32'(bus.SUM), 32'd0);
    check("rst_id", 32'(bus.OUT_ID), 32'd0);
    tick();
    rst     = 1'b0;
    bus.REQ = 4'b0000;
    tick();

    // Single request and carry chain cases
    run_add(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    run_add(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_add(2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_add(3, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    run_add(0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0);

    // All four requesting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_op(k, 16'(16'h1000 * (k + 1)), 16'(k), 1'b0);
    bus.REQ = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c <= 4) check("rr_gnt", 32'(bus.GNT), 32'(1 << (c % 4)));
      else        check("rr_gnt_idle", 32'(bus.GNT), 32'd0);
      if (c >= 2) begin
        check("rr_vld", 32'(bus.OUT_VALID), 32'd1);
        check("rr_id", 32'(bus.OUT_ID), 32'((c - 2) % 4));
        check("rr_sum", 32'(bus.SUM), 32'(16'h1000 * (((c - 2) % 4) + 1) + ((c - 2) % 4)));
      end else begin
        check("rr_vld_fill", 32'(bus.OUT_VALID), 32'd0);
      end
      tick();
      if (c == 4) bus.REQ = 4'b0000;
    end
    @(negedge clk);
    check("rr_drained", 32'(bus.OUT_VALID), 32'd0);
    tick();

    // Backpressure: pointer is at 1, so requester 1 wins first
    set_op(0, 16'h0100, 16'h0001, 1'b0);
    set_op(1, 16'h0200, 16'h0002, 1'b0);
    set_op(2, 16'h0300, 16'h0003, 1'b0);
    bus.REQ = 4'b0011;
    @(negedge clk);
    check("bp_gnt1", 32'(bus.GNT), 32'b0010);
    tick();
    bus.REQ = 4'b0001;
    @(negedge clk);
    check("bp_gnt0", 32'(bus.GNT), 32'b0001);
    tick();
    bus.REQ       = 4'b0100;
    bus.OUT_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_gnt", 32'(bus.GNT), 32'd0);
      check("bp_stall_vld", 32'(bus.OUT_VALID), 32'd1);
      check("bp_stall_id", 32'(bus.OUT_ID), 32'd1);
      check("bp_stall_sum", 32'(bus.SUM), 32'h0202);
      check("bp_stall_busy", 32'(bus.BUSY), 32'd1);
      tick();
    end
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    check("bp_rel_gnt", 32'(bus.GNT), 32'b0100);
    check("bp_rel_id", 32'(bus.OUT_ID), 32'd1);
    check("bp_rel_sum", 32'(bus.SUM), 32'h0202);
    tick();
    bus.REQ = 4'b0000;
    @(negedge clk);
    check("bp_2nd_vld", 32'(bus.OUT_VALID), 32'd1);
    check("bp_2nd_id", 32'(bus.OUT_ID), 32'd0);
    check("bp_2nd_sum", 32'(bus.SUM), 32'h0101);
    tick();
    @(negedge clk);
    check("bp_3rd_id", 32'(bus.OUT_ID), 32'd2);
    check("bp_3rd_sum", 32'(bus.SUM), 32'h0303);
    tick();
    @(negedge clk);
    check("bp_drained", 32'(bus.OUT_VALID), 32'd0);
    tick();

    // Pointer fairness: requesters 0 and 2 alternate
    bus.REQ = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fair_gnt", 32'(bus.GNT), (c % 2 == 0) ? 32'b0001 : 32'b0100);
      tick();
    end
    bus.REQ = 4'b0000;
    tick();
    tick();
    @(negedge clk);
    check("fair_drained", 32'(bus.BUSY), 32'd0);
    tick();

    // Asynchronous reset with both stages full
    set_op(1, 16'h0005, 16'h0007, 1'b0);
    set_op(2, 16'h0010, 16'h0020, 1'b0);
    bus.REQ       = 4'b0110;
    bus.OUT_READY = 1'b0;
    @(negedge clk);
    check("mr_gnt1", 32'(bus.GNT), 32'b0010);
    tick();
    @(negedge clk);
    check("mr_gnt2", 32'(bus.GNT), 32'b0100);
    tick();
    @(negedge clk);
    check("mr_full_gnt", 32'(bus.GNT), 32'd0);
    check("mr_full_busy", 32'(bus.BUSY), 32'd1);
    check("mr_full_sum", 32'(bus.SUM), 32'h000C);
    #2;
    rst = 1'b1;
    #1;
    check("mr_vld", 32'(bus.OUT_VALID), 32'd0);
    check("mr_busy", 32'(bus.BUSY), 32'd0);
    check("mr_gnt", 32'(bus.GNT), 32'd0);
    check("mr_sum", 32'(bus.SUM), 32'd0);
    check("mr_cout", 32'(bus.COUT), 32'd0);
    check("mr_id", 32'(bus.OUT_ID), 32'd0);
    tick();
    rst           = 1'b0;
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    check("mr_regrant", 32'(bus.GNT), 32'b0010);
    check("mr_post_vld", 32'(bus.OUT_VALID), 32'd0);
    tick();
    bus.REQ = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ks_add_arbiter.md
# ks_add_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one 16-bit Kogge-Stone adder among four requesters. Each requester presents operands and a carry-in with a request; the block grants one per cycle, registers the operands, evaluates the shared adder, and returns a tagged sum under valid/ready backpressure. It sits between the client logic and the prefix-adder datapath (generate/propagate stage, prefix layers 1–4, sum stage), which it instantiates unchanged as a purely combinational core.

## Interface
- Parameter `WIDTH`, default 16: operand width. Only 16 is supported, matching the four prefix layers.
- Parameter `NREQ`, default 4: number of requesters. Fixed at 4, so the ID is 2 bits.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `REQ` input 4: per-requester request. Must be held until granted.
- `A` input 64: packed operand A. Requester k uses `A[16k+15:16k]`.
- `B` input 64: packed operand B, same packing as `A`.
- `CI` input 4: per-requester carry-in.
- `GNT` output 4: one-hot grant, combinational. The operands of the granted requester are captured at this edge.
- `OUT_VALID` output 1: result valid.
- `OUT_READY` input 1: consumer ready.
- `OUT_ID` output 2: index of the requester that owns the result.
- `SUM` output 16: sum.
- `COUT` output 1: carry-out, i.e. bit 16 of A+B+CI.
- `BUSY` output 1: high when either pipeline stage holds valid data.

## Operation
- **Stage S1 (operand register).** Holds `v1`, `a1`, `b1`, `ci1`, `id1`. The adder core is driven from the S1 registers.
- **Stage S2 (result register).** Holds `v2`, `SUM`, `COUT`, `OUT_ID`. `OUT_VALID` = `v2`.
- **Advance rules:**
  - `adv2` = `v1` & (~`v2` | `OUT_READY`).
  - `load1` = ~`v1` | `adv2`.
- **Grant.** When `load1` is high and `REQ` ≠ 0, exactly one `GNT` bit is asserted. Otherwise `GNT` = 0.
- **Round-robin.** Search starts at `ptr`, with wrap-around 3→0. On each grant, `ptr` ← granted index + 1 mod 4. `ptr` is unchanged when there is no grant.
- **S1 update.**
  - On a grant: load the granted requester's A, B, CI and index, and set `v1` = 1.
  - Else if `adv2`: set `v1` = 0.
- **S2 update.**
  - On `adv2`: load the adder outputs and `id1`, and set `v2` = 1.
  - Else if `OUT_READY`: set `v2` = 0.
- **Hold under backpressure.** While `v2` & ~`OUT_READY`, `SUM`/`COUT`/`OUT_ID` stay stable.
- **Arithmetic.** {`COUT`,`SUM`} = A + B + CI, computed modulo 2^17. No saturation.
- **Simultaneous events.** Drain and refill of the same stage in one cycle is legal; full throughput is one result per cycle.
- **Reset values.**
  - `v1`, `v2`, `ptr` = 0.
  - `SUM` = 0, `COUT` = 0, `OUT_ID` = 0.
  - `OUT_VALID` = 0, `BUSY` = 0.
  - `GNT` = 0 while `RST` is high.
- **Reset mid-operation.** In-flight results are discarded, not replayed. Requesters keep `REQ` high and are re-granted after release.

## Timing
- A grant in cycle N puts the result on `OUT_VALID` in cycle N+2, provided there is no backpressure.
- Each cycle `OUT_READY` is low while `v2` = 1 adds one cycle to that result and stalls S1. Once S1 is also full, `GNT` = 0.
- The combinational path is the S1 registers → 16-bit adder → S2 registers. No other logic sits in that path.
- `GNT` depends combinationally on `REQ`, `v1`, `v2`, `OUT_READY` and `ptr`.

## Test plan
- **Single request.** REQ=0001, A0=0x1234, B0=0x1111, CI0=0.
  - GNT=0001 in cycle N.
  - Cycle N+2: OUT_VALID=1, SUM=0x2345, COUT=0, OUT_ID=0.
- **All four requesting from reset.** REQ=1111 held, OUT_READY=1.
  - Grants occur in order 0,1,2,3,0 on consecutive cycles.
  - One result per cycle with OUT_ID 0,1,2,3.
- **Carry chain and overflow.**
  - 0xFFFF+0x0001+0 → SUM=0x0000, COUT=1.
  - 0xFFFF+0x0000+1 → SUM=0x0000, COUT=1.
  - 0x8000+0x8000+1 → SUM=0x0001, COUT=1.
- **Backpressure.** Two results are in flight and OUT_READY is held low for 3 cycles.
  - SUM/OUT_ID stay stable and GNT=0 during the stall.
  - After OUT_READY rises, both results emerge in order with no loss or duplication.
- **Pointer fairness.** REQ=0101 held.
  - Grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- **Reset mid-operation.** Assert RST asynchronously with both stages full.
  - OUT_VALID, BUSY and GNT fall to 0 immediately; SUM/COUT/OUT_ID reset to 0.
  - After release, the first grant goes to the lowest-index active requester.
